mlcd_line_tx: RTL

//  Consumer (read side) of the pixel sfifo. Drains line bytes from the FIFO and serialises them onto the

---
 rtl/mlcd_line_tx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mlcd_line_tx.sv
// Memory-LCD line transmitter: drains line bytes from the pixel FIFO and shifts one
// multi-line write frame (command, per-line address, data, dummy trailers) out on SCS/SCLK/SI.
module mlcd_line_tx #(
    parameter int LINE_BYTES = 16,
    parameter int NUM_LINES  = 128,
    parameter int CLK_DIV    = 4,
    parameter int SCS_SETUP  = 8,
    parameter int SCS_HOLD   = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_vcom,
    input  logic [7:0] i_rdata,
    input  logic       i_rempty,
    output logic       o_rinc,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_stall,
    output logic       o_scs,
    output logic       o_sclk,
    output logic       o_si
);
    localparam int BIT_CYC = 2 * CLK_DIV;
    localparam int CNT_MAX = (BIT_CYC > SCS_SETUP) ? ((BIT_CYC > SCS_HOLD) ? BIT_CYC : SCS_HOLD)
                                                   : ((SCS_SETUP > SCS_HOLD) ? SCS_SETUP : SCS_HOLD);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int LW = $clog2(NUM_LINES + 1);
    localparam int BW = $clog2(LINE_BYTES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_LTRAIL, S_FTRAIL, S_HOLD, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [LW-1:0] line_q, line_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [7:0]    stage_q, stage_d;
    logic          stage_vld_q, stage_vld_d;
    logic          pend_q, pend_d;
    logic          stall_q, stall_d;
    logic          vcom_q, vcom_d;
    logic          scs_q, scs_d;
    logic          sclk_q, sclk_d;
    logic          si_q, si_d;

    logic       in_byte, last_cyc, next_is_data, avail, fetch_win;
    logic       load_en, take_data;
    logic [7:0] load_byte, avail_byte;

    assign in_byte      = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA) ||
                          (state_q == S_LTRAIL) || (state_q == S_FTRAIL);
    assign last_cyc     = (cnt_q == CW'(BIT_CYC - 1));
    assign next_is_data = (state_q == S_ADDR) ||
                          ((state_q == S_DATA) && (byte_q != BW'(LINE_BYTES - 1)));
    // A byte in flight from the FIFO (pend_q) is usable the same cycle via i_rdata.
    assign avail        = stage_vld_q || pend_q;
    assign avail_byte   = stage_vld_q ? stage_q : i_rdata;
    assign fetch_win    = stall_q || (in_byte && (bit_q == 3'd7) && next_is_data);

    assign o_rinc  = fetch_win && !stage_vld_q && !pend_q && !i_rempty;
    assign o_busy  = (state_q != S_IDLE);
    assign o_done  = (state_q == S_DONE);
    assign o_stall = stall_q;
    assign o_scs   = scs_q;
    assign o_sclk  = sclk_q;
    assign o_si    = si_q;

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        line_d      = line_q;
        byte_d      = byte_q;
        stage_d     = stage_q;
        stage_vld_d = stage_vld_q;
        pend_d      = o_rinc;
        stall_d     = stall_q;
        vcom_d      = vcom_q;
        scs_d       = scs_q;
        sclk_d      = sclk_q;
        si_d        = si_q;
        load_en     = 1'b0;
        load_byte   = 8'h00;
        take_data   = 1'b0;

        case (state_q)
            S_IDLE: if (i_start) begin
                state_d     = S_SETUP;
                scs_d       = 1'b1;
                vcom_d      = i_vcom;
                cnt_d       = '0;
                bit_d       = '0;
                line_d      = LW'(1);
                byte_d      = '0;
                stall_d     = 1'b0;
                stage_vld_d = 1'b0;
                sclk_d      = 1'b0;
                si_d        = 1'b0;
            end
            S_SETUP: if (cnt_q == CW'(SCS_SETUP - 1)) begin
                state_d   = S_CMD;
                load_en   = 1'b1;
                load_byte = {6'b0, vcom_q, 1'b1};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            S_HOLD: if (cnt_q == CW'(SCS_HOLD - 1)) begin
                state_d = S_DONE;
                scs_d   = 1'b0;
                si_d    = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        if (in_byte) begin
            if (stall_q) begin
                // SCLK parked low and SI held until the FIFO delivers the byte.
                if (avail) begin
                    load_en   = 1'b1;
                    load_byte = avail_byte;
                    take_data = 1'b1;
                    stall_d   = 1'b0;
                end
            end else if (!last_cyc) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(CLK_DIV - 1)) sclk_d = 1'b1;
            end else if (bit_q != 3'd7) begin
                cnt_d  = '0;
                bit_d  = bit_q + 3'd1;
                sclk_d = 1'b0;
                si_d   = sh_q[0];
                sh_d   = {1'b0, sh_q[7:1]};
            end else begin
                cnt_d  = '0;
                bit_d  = '0;
                sclk_d = 1'b0;
                case (state_q)
                    S_CMD: begin
                        state_d   = S_ADDR;
                        load_en   = 1'b1;
                        load_byte = 8'(line_q);
                    end
                    S_ADDR, S_DATA: begin
                        if ((state_q == S_DATA) && (byte_q == BW'(LINE_BYTES - 1))) begin
                            state_d = S_LTRAIL;
                            load_en = 1'b1;
                        end else begin
                            state_d = S_DATA;
                            byte_d  = (state_q == S_ADDR) ? '0 : byte_q + BW'(1);
                            if (avail) begin
                                load_en   = 1'b1;
                                load_byte = avail_byte;
                                take_data = 1'b1;
                            end else begin
                                stall_d = 1'b1;
                            end
                        end
                    end
                    S_LTRAIL: begin
                        load_en = 1'b1;
                        if (line_q == LW'(NUM_LINES)) begin
                            state_d = S_FTRAIL;
                        end else begin
                            state_d   = S_ADDR;
                            line_d    = line_q + LW'(1);
                            load_byte = 8'(line_q) + 8'd1;
                        end
                    end
                    default: begin
                        state_d = S_HOLD;
                        si_d    = 1'b0;
                    end
                endcase
            end
        end

        if (load_en) begin
            cnt_d  = '0;
            bit_d  = '0;
            sclk_d = 1'b0;
            si_d   = load_byte[0];
            sh_d   = {1'b0, load_byte[7:1]};
        end

        if (take_data && stage_vld_q) stage_vld_d = 1'b0;
        if (pend_q && !take_data) begin
            stage_d     = i_rdata;
            stage_vld_d = 1'b1;
        end
    end

    // NOTE: registered state uses non-blocking assignments; reset is asynchronous so SCS drops at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            line_q      <= '0;
            byte_q      <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            pend_q      <= 1'b0;
            stall_q     <= 1'b0;
            vcom_q      <= 1'b0;
            scs_q       <= 1'b0;
            sclk_q      <= 1'b0;
            si_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            line_q      <= line_d;
            byte_q      <= byte_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            pend_q      <= pend_d;
            stall_q     <= stall_d;
            vcom_q      <= vcom_d;
            scs_q       <= scs_d;
            sclk_q      <= sclk_d;
            si_q        <= si_d;
        end
    end
endmodule
